// File: rtl/sseg_scan_driver_if.sv
// Signal bundle between a value source and the seven-segment scan driver.
interface sseg_scan_driver_if #(
  parameter int unsigned NUM_W  = 16,
  parameter int unsigned DIGITS = 5
);
  logic [NUM_W-1:0]  num;
  logic              en;
  logic              blank_en;
  logic [DIGITS-1:0] dp_mask;
  logic [0:6]        sseg;
  logic              dp;
  logic [DIGITS-1:0] an;
  logic              ovf;
  logic              conv_done;

  modport master (
    output num, en, blank_en, dp_mask,
    input  sseg, dp, an, ovf, conv_done
  );

  modport slave (
    input  num, en, blank_en, dp_mask,
    output sseg, dp, an, ovf, conv_done
  );
endinterface

// File: rtl/sseg_scan_driver.sv
// Multiplexed common-anode seven-segment driver: a free-running double-dabble
// engine converts num to BCD, and a prescaled scanner walks the digits with
// leading-zero blanking, per-digit decimal points and overflow dashes.
module sseg_scan_driver #(
  parameter int unsigned NUM_W    = 16,
  parameter int unsigned DIGITS   = 5,
  parameter int unsigned PRESCALE = 16
) (
  input logic               clk,
  input logic               rst,
  sseg_scan_driver_if.slave bus
);

  localparam int unsigned NI = (NUM_W + 2) / 3;
  localparam int unsigned BW = 4 * NI;
  localparam int unsigned DW = 4 * DIGITS;
  localparam int unsigned XW = (NI > DIGITS) ? BW : DW;
  localparam int unsigned CW = $clog2(NUM_W + 1);
  localparam int unsigned PW = $clog2(PRESCALE);
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [0:6] SEG_BLANK = 7'b1111111;
  localparam logic [0:6] SEG_DASH  = 7'b1111110;

  typedef enum logic [1:0] {
    CAPTURE,
    SHIFT,
    COMMIT
  } conv_state_t;

  conv_state_t state_q, state_d;

  logic [NUM_W-1:0]  bin_q;
  logic [BW-1:0]     bcd_q;
  logic [BW-1:0]     bcd_adj;
  logic [XW-1:0]     bcd_ext;
  logic [CW-1:0]     cnt_q;
  logic [DW-1:0]     disp_q, disp_d;
  logic              ovf_q, ovf_d;
  logic              done_q;

  logic [PW-1:0]     presc_q;
  logic [IW-1:0]     idx_q;
  logic [DIGITS-1:0] upper_zero;
  logic              zero_run;
  logic [3:0]        cur_nib;
  logic              blank;
  logic [0:6]        seg_d;

  logic [0:6]        sseg_q;
  logic              dp_q;
  logic [DIGITS-1:0] an_q;

  // Active-low segment patterns a..g for decimal digits; other codes go dark.
  function automatic logic [0:6] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    seg_decode = 7'b0000001;
      4'd1:    seg_decode = 7'b1001111;
      4'd2:    seg_decode = 7'b0010010;
      4'd3:    seg_decode = 7'b0000110;
      4'd4:    seg_decode = 7'b1001100;
      4'd5:    seg_decode = 7'b0100100;
      4'd6:    seg_decode = 7'b0100000;
      4'd7:    seg_decode = 7'b0001111;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0000100;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

  // Conversion state register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= CAPTURE;
    else      state_q <= state_d;
  end

  // Conversion sequencing: capture, NUM_W shift steps, commit, repeat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CAPTURE: state_d = SHIFT;
      SHIFT:   if (cnt_q == CW'(NUM_W - 1)) state_d = COMMIT;
      COMMIT:  state_d = CAPTURE;
      default: state_d = CAPTURE;
    endcase
  end

  // Add-3 correction on every BCD nibble that would overflow when doubled.
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < NI; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Split the finished BCD into the visible digits and the overflow digits.
  always_comb begin
    bcd_ext = XW'(bcd_q);
    disp_d  = bcd_ext[DW-1:0];
    ovf_d   = |(bcd_ext >> DW);
  end

  // Double-dabble datapath and result commit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      disp_q <= '0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        CAPTURE: begin
          bin_q <= bus.num;
          bcd_q <= '0;
          cnt_q <= '0;
        end
        SHIFT: begin
          bin_q <= {bin_q[NUM_W-2:0], 1'b0};
          // The top adjusted bit can never be set for an in-range input.
          bcd_q <= BW'({bcd_adj, bin_q[NUM_W-1]});
          cnt_q <= cnt_q + CW'(1);
        end
        COMMIT: begin
          disp_q <= disp_d;
          ovf_q  <= ovf_d;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Slot timer and digit index walking 0..DIGITS-1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else if (presc_q == PW'(PRESCALE - 1)) begin
      presc_q <= '0;
      idx_q   <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  // upper_zero[i] is set when digit i and every digit above it are zero.
  always_comb begin
    upper_zero = '0;
    zero_run   = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      zero_run = zero_run & (disp_q[4*(DIGITS-1-k) +: 4] == 4'd0);
      upper_zero[DIGITS-1-k] = zero_run;
    end
  end

  // Segment pattern for the active digit; overflow dashes win over blanking.
  always_comb begin
    cur_nib = disp_q[4*idx_q +: 4];
    blank   = bus.blank_en && (idx_q != '0) && upper_zero[idx_q];
    if (ovf_q)      seg_d = SEG_DASH;
    else if (blank) seg_d = SEG_BLANK;
    else            seg_d = seg_decode(cur_nib);
  end

  // Registered pin drivers so anode, segments and point switch together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sseg_q <= SEG_BLANK;
      dp_q   <= 1'b1;
      an_q   <= '1;
    end else begin
      sseg_q <= seg_d;
      dp_q   <= ~bus.dp_mask[idx_q];
      an_q   <= bus.en ? ~(DIGITS'(1) << idx_q) : '1;
    end
  end

  assign bus.sseg      = sseg_q;
  assign bus.dp        = dp_q;
  assign bus.an        = an_q;
  assign bus.ovf       = ovf_q;
  assign bus.conv_done = done_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Directed bench for sseg_scan_driver in three configurations.
module tb_sseg_scan_driver;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  localparam logic [0:6] S0 = 7'b0000001;
  localparam logic [0:6] S1 = 7'b1001111;
  localparam logic [0:6] S2 = 7'b0010010;
  localparam logic [0:6] S3 = 7'b0000110;
  localparam logic [0:6] S4 = 7'b1001100;
  localparam logic [0:6] S5 = 7'b0100100;
  localparam logic [0:6] S6 = 7'b0100000;
  localparam logic [0:6] S7 = 7'b0001111;
  localparam logic [0:6] S9 = 7'b0000100;
  localparam logic [0:6] SB = 7'b1111111;
  localparam logic [0:6] SD = 7'b1111110;

  sseg_scan_driver_if #(.NUM_W(16), .DIGITS(5)) bus_a ();
  sseg_scan_driver_if #(.NUM_W(20), .DIGITS(5)) bus_b ();
  sseg_scan_driver_if #(.NUM_W(10), .DIGITS(3)) bus_c ();

  sseg_scan_driver #(.NUM_W(16), .DIGITS(5), .PRESCALE(16)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  sseg_scan_driver #(.NUM_W(20), .DIGITS(5), .PRESCALE(4)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );
  sseg_scan_driver #(.NUM_W(10), .DIGITS(3), .PRESCALE(4)) dut_c (
    .clk(clk), .rst(rst), .bus(bus_c)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int which, input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick(1);
      case (which)
        0:       found = bus_a.conv_done;
        1:       found = bus_b.conv_done;
        default: found = bus_c.conv_done;
      endcase
    end
    check({tag, "_done_seen"}, 32'(found), 32'd1);
  endtask

  // Walk one full scan of DUT A starting at the next entry into slot 0.
  task automatic scan_a(input string tag, input logic [0:6] e0, input logic [0:6] e1,
                        input logic [0:6] e2, input logic [0:6] e3, input logic [0:6] e4);
    logic [4:0] an_exp [5];
    logic [0:6] seg_exp [5];
    logic [4:0] prev;
    logic       found;
    an_exp  = '{5'b11110, 5'b11101, 5'b11011, 5'b10111, 5'b01111};
    seg_exp = '{e0, e1, e2, e3, e4};
    found   = 1'b0;
    prev    = bus_a.an;
    for (int i = 0; i < 200 && !found; i++) begin
      tick(1);
      if (bus_a.an == 5'b11110 && prev != 5'b11110) found = 1'b1;
      prev = bus_a.an;
    end
    check({tag, "_sync"}, 32'(found), 32'd1);
    for (int d = 0; d < 5; d++) begin
      check($sformatf("%s_an_start%0d", tag, d), 32'(bus_a.an), 32'(an_exp[d]));
      check($sformatf("%s_seg_start%0d", tag, d), 32'(bus_a.sseg), 32'(seg_exp[d]));
      tick(15);
      check($sformatf("%s_an_end%0d", tag, d), 32'(bus_a.an), 32'(an_exp[d]));
      check($sformatf("%s_seg_end%0d", tag, d), 32'(bus_a.sseg), 32'(seg_exp[d]));
      tick(1);
    end
    check({tag, "_wrap"}, 32'(bus_a.an), 32'(5'b11110));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [2:0] an_c_exp [3];
    logic [0:6] seg_c_exp [3];
    logic       dp_c_exp [3];
    logic [2:0] prev_c;
    logic       found;

    bus_a.num = 16'd12345;  bus_a.en = 1'b1; bus_a.blank_en = 1'b0; bus_a.dp_mask = 5'b00000;
    bus_b.num = 20'd123456; bus_b.en = 1'b1; bus_b.blank_en = 1'b0; bus_b.dp_mask = 5'b00000;
    bus_c.num = 10'd456;    bus_c.en = 1'b1; bus_c.blank_en = 1'b0; bus_c.dp_mask = 3'b010;

    // Reset state.
    rst = 1'b0;
    tick(5);
    check("rst_an",   32'(bus_a.an),        32'(5'b11111));
    check("rst_sseg", 32'(bus_a.sseg),      32'(SB));
    check("rst_dp",   32'(bus_a.dp),        32'd1);
    check("rst_ovf",  32'(bus_a.ovf),       32'd0);
    check("rst_done", 32'(bus_a.conv_done), 32'd0);
    check("rst_an_c", 32'(bus_c.an),        32'(3'b111));

    // First commit lands on the 18th edge after release.
    rst = 1'b1;
    tick(1);
    check("first_an", 32'(bus_a.an), 32'(5'b11110));
    tick(16);
    check("done_early", 32'(bus_a.conv_done), 32'd0);
    tick(1);
    check("done_18", 32'(bus_a.conv_done), 32'd1);
    check("ovf_12345", 32'(bus_a.ovf), 32'd0);
    tick(1);
    check("done_pulse", 32'(bus_a.conv_done), 32'd0);

    scan_a("d12345", S5, S4, S3, S2, S1);

    // Leading-zero blanking.
    bus_a.blank_en = 1'b1;
    bus_a.num = 16'd7;
    wait_done(0, "n7a");
    wait_done(0, "n7b");
    scan_a("blank7", S7, SB, SB, SB, SB);
    bus_a.num = 16'd0;
    wait_done(0, "n0a");
    wait_done(0, "n0b");
    scan_a("blank0", S0, SB, SB, SB, SB);

    // Input change mid-SHIFT is ignored until the following capture.
    bus_a.blank_en = 1'b0;
    wait_done(0, "pre_mid");
    bus_a.num = 16'd11111;
    tick(1);
    tick(5);
    bus_a.num = 16'd22222;
    wait_done(0, "mid1");
    tick(1);
    check("mid_old_num", 32'(bus_a.sseg), 32'(S1));
    wait_done(0, "mid2");
    tick(1);
    check("mid_new_num", 32'(bus_a.sseg), 32'(S2));

    // Reset in the middle of SHIFT discards everything.
    wait_done(0, "pre_rst");
    tick(4);
    rst = 1'b0;
    tick(1);
    check("mrst_an",   32'(bus_a.an),        32'(5'b11111));
    check("mrst_sseg", 32'(bus_a.sseg),      32'(SB));
    check("mrst_dp",   32'(bus_a.dp),        32'd1);
    check("mrst_ovf",  32'(bus_a.ovf),       32'd0);
    check("mrst_done", 32'(bus_a.conv_done), 32'd0);
    rst = 1'b1;
    tick(1);
    check("mrst_an0",  32'(bus_a.an),   32'(5'b11110));
    check("mrst_disp0", 32'(bus_a.sseg), 32'(S0));
    tick(16);
    check("mrst_done_early", 32'(bus_a.conv_done), 32'd0);
    tick(1);
    check("mrst_done_18", 32'(bus_a.conv_done), 32'd1);

    // Overflow on the wide configuration, then back in range.
    wait_done(1, "b_ovf1");
    wait_done(1, "b_ovf2");
    check("b_ovf_set", 32'(bus_b.ovf), 32'd1);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check($sformatf("b_dash%0d", i), 32'(bus_b.sseg), 32'(SD));
    end
    bus_b.num = 20'd99999;
    wait_done(1, "b_99a");
    wait_done(1, "b_99b");
    check("b_ovf_clr", 32'(bus_b.ovf), 32'd0);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check($sformatf("b_nine%0d", i), 32'(bus_b.sseg), 32'(S9));
    end

    // Short-prescale scan with a decimal point on digit 1.
    an_c_exp  = '{3'b110, 3'b101, 3'b011};
    seg_c_exp = '{S6, S5, S4};
    dp_c_exp  = '{1'b1, 1'b0, 1'b1};
    wait_done(2, "c_conv");
    found  = 1'b0;
    prev_c = bus_c.an;
    for (int i = 0; i < 50 && !found; i++) begin
      tick(1);
      if (bus_c.an == 3'b110 && prev_c != 3'b110) found = 1'b1;
      prev_c = bus_c.an;
    end
    check("c_sync", 32'(found), 32'd1);
    for (int d = 0; d < 3; d++) begin
      for (int c = 0; c < 4; c++) begin
        check($sformatf("c_an%0d_%0d", d, c),   32'(bus_c.an),   32'(an_c_exp[d]));
        check($sformatf("c_dp%0d_%0d", d, c),   32'(bus_c.dp),   32'(dp_c_exp[d]));
        check($sformatf("c_seg%0d_%0d", d, c), 32'(bus_c.sseg), 32'(seg_c_exp[d]));
        tick(1);
      end
    end
    check("c_wrap", 32'(bus_c.an), 32'(3'b110));
    bus_c.en = 1'b0;
    tick(1);
    check("c_en_off", 32'(bus_c.an), 32'(3'b111));
    check("c_ovf", 32'(bus_c.ovf), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
